// File: rtl/game_state_fsm_if.sv
// Game sequencer bus: keyboard/VGA/collision inputs and the HUD/State outputs.
interface game_state_fsm_if;
    logic        VGA_VS;
    logic [7:0]  keycode;
    logic        collision;
    logic [2:0]  State;
    logic        game_reset;
    logic        game_over;
    logic [15:0] survive_frames;
    logic [9:0]  survive_secs;
    logic [9:0]  best_secs;
    logic        new_best;

    modport master (
        output VGA_VS, keycode, collision,
        input  State, game_reset, game_over, survive_frames, survive_secs,
               best_secs, new_best
    );

    modport slave (
        input  VGA_VS, keycode, collision,
        output State, game_reset, game_over, survive_frames, survive_secs,
               best_secs, new_best
    );
endinterface

// File: rtl/game_state_fsm.sv
// Top-level game sequencer: menu / three levels / game-over, survival timers
// counted in VGA frames, best-time record and a restart pulse for the walls.
//
// state | meaning
// ------+---------------------------------------------------------------
//   0   | MENU: waiting for a start press, timers show the last run
//   1   | LEVEL1: run in progress, advances at LVL2_FRAMES
//   2   | LEVEL2: run in progress, advances at LVL3_FRAMES
//   3   | LEVEL3: run in progress until a collision
//   4   | GAME_OVER: timers frozen, restart allowed after GAMEOVER_HOLD frames
//  5-7  | illegal, recovers to MENU
module game_state_fsm #(
    parameter logic [7:0] START_KEY      = 8'h2C,
    parameter int         LVL2_FRAMES    = 600,
    parameter int         LVL3_FRAMES    = 1800,
    parameter int         FRAMES_PER_SEC = 60,
    parameter int         GAMEOVER_HOLD  = 120
) (
    input  logic             Clk,
    input  logic             Reset_h,
    game_state_fsm_if.slave  bus
);
    localparam logic [2:0] S_MENU = 3'd0;
    localparam logic [2:0] S_LVL1 = 3'd1;
    localparam logic [2:0] S_LVL2 = 3'd2;
    localparam logic [2:0] S_LVL3 = 3'd3;
    localparam logic [2:0] S_OVER = 3'd4;

    localparam int SUB_W  = $clog2(FRAMES_PER_SEC);
    localparam int HOLD_W = $clog2(GAMEOVER_HOLD + 1);

    localparam logic [15:0]       LVL2_F   = 16'(LVL2_FRAMES);
    localparam logic [15:0]       LVL3_F   = 16'(LVL3_FRAMES);
    localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(FRAMES_PER_SEC - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(GAMEOVER_HOLD);
    localparam logic [9:0]        SECS_MAX = 10'd999;

    logic [2:0]        state, state_next;
    logic              vs_sync1, vs_sync2, vs_prev, frame_tick;
    logic [7:0]        key_prev;
    logic [15:0]       frames, frames_nx;
    logic [9:0]        secs, secs_nx;
    logic [SUB_W-1:0]  sub_cnt, sub_nx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [9:0]        best;
    logic              new_best_r, game_reset_r, game_over_r;

    logic start_evt, in_level, entering_l1, entering_over;

    assign start_evt     = (bus.keycode == START_KEY) && (key_prev != START_KEY);
    assign in_level      = (state == S_LVL1) || (state == S_LVL2) || (state == S_LVL3);
    assign entering_l1   = (state_next == S_LVL1) && (state != S_LVL1);
    assign entering_over = (state_next == S_OVER) && (state != S_OVER);

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset_h) state <= S_MENU;
        else         state <= state_next;
    end

    // Next-state decode; collision outranks a level advance.
    always_comb begin
        state_next = state;
        case (state)
            S_MENU: if (start_evt) state_next = S_LVL1;
            S_LVL1: begin
                if (bus.collision)         state_next = S_OVER;
                else if (frames == LVL2_F) state_next = S_LVL2;
            end
            S_LVL2: begin
                if (bus.collision)         state_next = S_OVER;
                else if (frames == LVL3_F) state_next = S_LVL3;
            end
            S_LVL3: if (bus.collision) state_next = S_OVER;
            S_OVER: if (start_evt && (hold_cnt == HOLD_MAX)) state_next = S_LVL1;
            default: state_next = S_MENU;
        endcase
    end

    // Timer increments for this cycle; the best-time compare uses these so a
    // collision landing on a frame tick still credits that frame.
    always_comb begin
        frames_nx = frames;
        secs_nx   = secs;
        sub_nx    = sub_cnt;
        if (in_level && frame_tick) begin
            if (frames != 16'hFFFF) frames_nx = frames + 16'd1;
            if (sub_cnt == SUB_LAST) begin
                sub_nx = '0;
                if (secs != SECS_MAX) secs_nx = secs + 10'd1;
            end else begin
                sub_nx = sub_cnt + 1'b1;
            end
        end
    end

    // VGA_VS synchroniser and frame-tick edge detect, plus key edge history.
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            vs_sync1   <= 1'b0;
            vs_sync2   <= 1'b0;
            vs_prev    <= 1'b0;
            frame_tick <= 1'b0;
            key_prev   <= 8'h00;
        end else begin
            vs_sync1   <= bus.VGA_VS;
            vs_sync2   <= vs_sync1;
            vs_prev    <= vs_sync2;
            frame_tick <= vs_sync2 & ~vs_prev;
            key_prev   <= bus.keycode;
        end
    end

    // Survival timers, best-time record, game-over hold and registered flags.
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            frames       <= '0;
            secs         <= '0;
            sub_cnt      <= '0;
            hold_cnt     <= '0;
            best         <= '0;
            new_best_r   <= 1'b0;
            game_reset_r <= 1'b0;
            game_over_r  <= 1'b0;
        end else begin
            game_reset_r <= entering_l1;
            game_over_r  <= (state_next == S_OVER);
            if (entering_l1) begin
                frames     <= '0;
                secs       <= '0;
                sub_cnt    <= '0;
                new_best_r <= 1'b0;
            end else begin
                frames  <= frames_nx;
                secs    <= secs_nx;
                sub_cnt <= sub_nx;
            end
            if (entering_over) begin
                hold_cnt <= '0;
                if (secs_nx > best) begin
                    best       <= secs_nx;
                    new_best_r <= 1'b1;
                end
            end else if ((state == S_OVER) && frame_tick && (hold_cnt != HOLD_MAX)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    // Drive the bus outputs from registered state.
    always_comb begin
        bus.State          = state;
        bus.game_reset     = game_reset_r;
        bus.game_over      = game_over_r;
        bus.survive_frames = frames;
        bus.survive_secs   = secs;
        bus.best_secs      = best;
        bus.new_best       = new_best_r;
    end
endmodule

// File: tb/tb_game_state_fsm.sv
// Bench for game_state_fsm: table of run phases with expected results queued
// at stimulus time and compared once the phase settles, plus hand sequences
// for reset, menu behaviour and held-key starts.
module tb_game_state_fsm;
    logic Clk = 1'b0;
    logic Reset_h = 1'b1;

    game_state_fsm_if bus ();

    game_state_fsm dut (
        .Clk     (Clk),
        .Reset_h (Reset_h),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        int          frames;
        logic        coll_last;
        logic [7:0]  key;
        logic        hold_key;
        logic [2:0]  exp_state;
        logic [15:0] exp_frames;
        logic [9:0]  exp_secs;
        logic [9:0]  exp_best;
        logic        exp_nb;
        int          exp_resets;
    } vec_t;

    vec_t vecs[15];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rst_pulses = 0;

    // Count game_reset pulses, sampled mid-cycle.
    always @(negedge Clk) if (bus.game_reset === 1'b1) rst_pulses++;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    task automatic check_all_zero(string tag);
        check({tag, " State"},          32'(bus.State), 0);
        check({tag, " game_reset"},     32'(bus.game_reset), 0);
        check({tag, " game_over"},      32'(bus.game_over), 0);
        check({tag, " survive_frames"}, 32'(bus.survive_frames), 0);
        check({tag, " survive_secs"},   32'(bus.survive_secs), 0);
        check({tag, " best_secs"},      32'(bus.best_secs), 0);
        check({tag, " new_best"},       32'(bus.new_best), 0);
    endtask

    // One VGA frame: a one-cycle VS pulse; the frame tick reaches the counters
    // on the third edge after it, and collision can be placed in that cycle.
    task automatic frame(input logic coll);
        bus.VGA_VS = 1'b1;
        @(posedge Clk); #1;
        bus.VGA_VS = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        bus.collision = coll;
        @(posedge Clk); #1;
        bus.collision = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        int   base;
        base = rst_pulses;
        exp_q.push_back(v);
        for (int i = 0; i < v.frames; i++) frame(v.coll_last && (i == v.frames - 1));
        if (v.key != 8'h00) begin
            if (!v.hold_key) begin
                bus.keycode = 8'h00;
                @(posedge Clk); #1;
            end
            bus.keycode = v.key;
            @(posedge Clk); #1;
            if (!v.hold_key) bus.keycode = 8'h00;
        end
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        @(negedge Clk);
        e = exp_q.pop_front();
        check({e.name, " State"},          32'(bus.State), 32'(e.exp_state));
        check({e.name, " game_over"},      32'(bus.game_over), 32'(e.exp_state == 3'd4));
        check({e.name, " survive_frames"}, 32'(bus.survive_frames), 32'(e.exp_frames));
        check({e.name, " survive_secs"},   32'(bus.survive_secs), 32'(e.exp_secs));
        check({e.name, " best_secs"},      32'(bus.best_secs), 32'(e.exp_best));
        check({e.name, " new_best"},       32'(bus.new_best), 32'(e.exp_nb));
        check({e.name, " reset_pulses"},   32'(rst_pulses - base), 32'(e.exp_resets));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        //            name            frm   col   key    hold  st    frames   secs   best  nb  rst
        vecs[0]  = '{"start",         0,    1'b0, 8'h2C, 1'b0, 3'd1, 16'd0,    10'd0,  10'd0,  1'b0, 1};
        vecs[1]  = '{"l1_599",        599,  1'b0, 8'h00, 1'b0, 3'd1, 16'd599,  10'd9,  10'd0,  1'b0, 0};
        vecs[2]  = '{"l1_to_l2",      1,    1'b0, 8'h00, 1'b0, 3'd2, 16'd600,  10'd10, 10'd0,  1'b0, 0};
        vecs[3]  = '{"l2_1799",       1199, 1'b0, 8'h00, 1'b0, 3'd2, 16'd1799, 10'd29, 10'd0,  1'b0, 0};
        vecs[4]  = '{"coll_vs_adv",   1,    1'b1, 8'h00, 1'b0, 3'd4, 16'd1800, 10'd30, 10'd30, 1'b1, 0};
        vecs[5]  = '{"go_hold50",     50,   1'b0, 8'h2C, 1'b0, 3'd4, 16'd1800, 10'd30, 10'd30, 1'b1, 0};
        vecs[6]  = '{"go_hold119",    69,   1'b0, 8'h2C, 1'b0, 3'd4, 16'd1800, 10'd30, 10'd30, 1'b1, 0};
        vecs[7]  = '{"go_restart",    1,    1'b0, 8'h2C, 1'b1, 3'd1, 16'd0,    10'd0,  10'd30, 1'b0, 1};
        vecs[8]  = '{"held_coll5s",   300,  1'b1, 8'h00, 1'b0, 3'd4, 16'd300,  10'd5,  10'd30, 1'b0, 0};
        vecs[9]  = '{"held_no_rst",   120,  1'b0, 8'h2C, 1'b1, 3'd4, 16'd300,  10'd5,  10'd30, 1'b0, 0};
        vecs[10] = '{"repress",       0,    1'b0, 8'h2C, 1'b0, 3'd1, 16'd0,    10'd0,  10'd30, 1'b0, 1};
        vecs[11] = '{"to_l3",         1800, 1'b0, 8'h00, 1'b0, 3'd3, 16'd1800, 10'd30, 10'd30, 1'b0, 0};
        vecs[12] = '{"equal_best",    1,    1'b1, 8'h00, 1'b0, 3'd4, 16'd1801, 10'd30, 10'd30, 1'b0, 0};
        vecs[13] = '{"restart2",      120,  1'b0, 8'h2C, 1'b0, 3'd1, 16'd0,    10'd0,  10'd30, 1'b0, 1};
        vecs[14] = '{"to_l3_again",   1800, 1'b0, 8'h00, 1'b0, 3'd3, 16'd1800, 10'd30, 10'd30, 1'b0, 0};

        bus.VGA_VS    = 1'b0;
        bus.keycode   = 8'h00;
        bus.collision = 1'b0;

        // Reset with VS toggling.
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            bus.VGA_VS = ~bus.VGA_VS;
        end
        bus.VGA_VS = 1'b0;
        @(posedge Clk); #1;
        Reset_h = 1'b0;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        check_all_zero("reset");
        @(posedge Clk); #1;

        foreach (vecs[i]) apply(vecs[i]);

        // Reset while in LEVEL3: everything, including best, returns to zero.
        Reset_h = 1'b1;
        @(negedge Clk);
        check_all_zero("reset_l3");
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk); #1;
            bus.VGA_VS = ~bus.VGA_VS;
        end
        bus.VGA_VS = 1'b0;
        @(negedge Clk);
        check_all_zero("reset_vs");
        @(posedge Clk); #1;
        Reset_h = 1'b0;
        repeat (6) @(posedge Clk);
        @(negedge Clk);
        check_all_zero("post_reset");

        // Collision in MENU is ignored.
        @(posedge Clk); #1;
        bus.collision = 1'b1;
        repeat (4) @(posedge Clk);
        #1 bus.collision = 1'b0;
        @(negedge Clk);
        check("menu_coll State", 32'(bus.State), 0);

        // Start key held across MENU->LEVEL1 gives a single start.
        base = rst_pulses;
        @(posedge Clk); #1;
        bus.keycode = 8'h2C;
        repeat (6) @(posedge Clk);
        @(negedge Clk);
        check("held_start State", 32'(bus.State), 1);
        check("held_start pulses", 32'(rst_pulses - base), 1);
        check("held_start frames", 32'(bus.survive_frames), 0);
        @(posedge Clk); #1;
        for (int i = 0; i < 300; i++) frame(i == 299);
        @(posedge Clk); #1;
        @(negedge Clk);
        check("first_best State", 32'(bus.State), 4);
        check("first_best best_secs", 32'(bus.best_secs), 5);
        check("first_best new_best", 32'(bus.new_best), 1);
        check("first_best pulses", 32'(rst_pulses - base), 1);
        bus.keycode = 8'h00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
